mem_axi_master: RTL
===================

MEM_AXI_MASTER -- requirements
Module: mem_axi_master

Interface
REQ-001 Parameter: TIMEOUT_CYC, 255, cycles an outstanding transaction may wait in one non-IDLE state before abort (1..255; counter is 8 bit).
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 req_valid_i  in  1  core memory request present.
REQ-005 req_wen_i  in  1  1 = write, 0 = read.
REQ-006 req_addr_i  in  32  byte address.
REQ-007 req_wdata_i  in  64  write data, already lane-aligned.
REQ-008 req_wmask_i  in  64  per-bit write mask, 1 = write bit.
REQ-009 req_ready_o  out  1  request accepted when valid & ready.
REQ-010 resp_valid_o  out  1  one-cycle completion pulse.
REQ-011 resp_rdata_o  out  64  read data; valid with resp_valid_o.
REQ-012 resp_err_o  out  1  completion was a timeout abort.
REQ-013 stall_o  out  1  hold core pipeline.
REQ-014 m_araddr_o out 32, m_arvalid_o out 1, m_arready_i in 1: read-address channel.
REQ-015 m_rdata_i in 64, m_rvalid_i in 1, m_rready_o out 1: read-data channel.
REQ-016 m_awaddr_o out 32, m_awvalid_o out 1, m_awready_i in 1: write-address channel.
REQ-017 m_wdata_o out 64, m_wmask_o out 64, m_wvalid_o out 1, m_wready_i in 1: write-data channel.
REQ-018 m_bvalid_i in 1, m_bready_o out 1: write-response channel.

Function
REQ-019 FSM states: IDLE, RADDR, RDATA, WREQ, WRESP; one transaction outstanding at most.
REQ-020 req_ready_o = 1 only in IDLE; on accept, addr/wdata/wmask latch into internal regs; next state RADDR (wen=0) or WREQ (wen=1).
REQ-021 All m_* address/data/mask outputs driven from latched regs; stable while the matching valid is high.
REQ-022 RADDR: m_arvalid_o=1; on m_arready_i -> RDATA; arvalid drops the next cycle.
REQ-023 RDATA: m_rready_o=1; on m_rvalid_i, resp_rdata_o <= m_rdata_i, resp_valid_o pulses 1 cycle, -> IDLE.
REQ-024 WREQ: m_awvalid_o and m_wvalid_o both assert on entry; each drops independently after its own handshake; -> WRESP once both handshakes done (same or different cycles).
REQ-025 WRESP: m_bready_o=1; on m_bvalid_i resp_valid_o pulses 1 cycle, resp_err_o=0, -> IDLE.
REQ-026 resp_rdata_o holds last read value until next read completion; write completions leave it unchanged.
REQ-027 Minimum latency, zero-wait responder: read accept -> resp_valid 2 cycles after accept edge; write likewise 2 cycles.
REQ-028 Timeout counter clears on every state entry, increments each cycle in non-IDLE states; at TIMEOUT_CYC without the awaited handshake: all m_*valid/ready drop, resp_valid_o=1, resp_err_o=1, resp_rdata_o=0 for reads, -> IDLE.
REQ-029 Handshake and timeout in same cycle: handshake wins, no error.
REQ-030 stall_o = (state != IDLE) | (req_valid_i & ~req_ready_o); stall_o deasserts in the resp_valid_o cycle.
REQ-031 A new request presented in the resp_valid_o cycle is not accepted until the following IDLE cycle.
REQ-032 m_rvalid_i / m_bvalid_i outside RDATA / WRESP are ignored.

Reset
REQ-033 rst low asynchronously forces IDLE, counter 0, all m_*valid/ready 0, resp_valid_o 0, resp_err_o 0, resp_rdata_o 0, latched regs 0.
REQ-034 Reset mid-transaction abandons it with no completion pulse; after rst high, first rising edge sees req_ready_o=1.

Verification
REQ-035 Read, zero-wait responder: addr 0x8000_0010, rdata 0x1122334455667788 -> arvalid 1 cycle, resp_valid with that data 2 cycles after accept, err 0.
REQ-036 Write, awready 1 cycle before wready: addr 0x8000_0020, wdata 0xFF, wmask 0xFF -> awvalid drops first, wvalid holds until wready, one bready handshake, one resp_valid, err 0.
REQ-037 Responder delays rvalid 5 cycles -> stall_o high throughout, exactly one resp_valid, data captured on rvalid edge.
REQ-038 TIMEOUT_CYC=4, arready never asserted -> resp_valid with resp_err_o=1, resp_rdata_o=0 after 4 cycles in RADDR, return to IDLE.
REQ-039 rst pulled low during WRESP -> all outputs reset immediately, no resp_valid; subsequent read completes normally.
REQ-040 Back-to-back requests held valid -> second accepted only after first resp_valid cycle, no overlap on m_* channels.

Source files
------------

// File: rtl/mem_axi_master_if.sv
// Memory-side bus of mem_axi_master: AXI-style read-address, read-data,
// write-address, write-data and write-response channels.
interface mem_axi_master_if;
  logic [31:0] m_araddr_o;
  logic        m_arvalid_o;
  logic        m_arready_i;
  logic [63:0] m_rdata_i;
  logic        m_rvalid_i;
  logic        m_rready_o;
  logic [31:0] m_awaddr_o;
  logic        m_awvalid_o;
  logic        m_awready_i;
  logic [63:0] m_wdata_o;
  logic [63:0] m_wmask_o;
  logic        m_wvalid_o;
  logic        m_wready_i;
  logic        m_bvalid_i;
  logic        m_bready_o;

  modport master (
    output m_araddr_o, m_arvalid_o,
    input  m_arready_i,
    input  m_rdata_i, m_rvalid_i,
    output m_rready_o,
    output m_awaddr_o, m_awvalid_o,
    input  m_awready_i,
    output m_wdata_o, m_wmask_o, m_wvalid_o,
    input  m_wready_i,
    input  m_bvalid_i,
    output m_bready_o
  );

  modport slave (
    input  m_araddr_o, m_arvalid_o,
    output m_arready_i,
    output m_rdata_i, m_rvalid_i,
    input  m_rready_o,
    input  m_awaddr_o, m_awvalid_o,
    output m_awready_i,
    input  m_wdata_o, m_wmask_o, m_wvalid_o,
    output m_wready_i,
    output m_bvalid_i,
    input  m_bready_o
  );
endinterface

// File: rtl/mem_axi_master.sv
// Core-to-memory bus bridge: one read or write outstanding, registered bus
// outputs, and a per-state timeout that aborts a stuck transaction with an error.
module mem_axi_master #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid_i,
  input  logic             req_wen_i,
  input  logic [31:0]      req_addr_i,
  input  logic [63:0]      req_wdata_i,
  input  logic [63:0]      req_wmask_i,
  output logic             req_ready_o,
  output logic             resp_valid_o,
  output logic [63:0]      resp_rdata_o,
  output logic             resp_err_o,
  output logic             stall_o,
  mem_axi_master_if.master m
);

  typedef enum logic [2:0] {IDLE, RADDR, RDATA, WREQ, WRESP} state_t;

  // Counter value reached on the last permitted cycle in a state.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYC - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [63:0] wmask_q, wmask_d;
  logic        arvalid_q, arvalid_d;
  logic        rready_q, rready_d;
  logic        awvalid_q, awvalid_d;
  logic        wvalid_q, wvalid_d;
  logic        bready_q, bready_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_err_q, resp_err_d;
  logic [63:0] rdata_q, rdata_d;

  logic timeout_hit;
  logic aw_ok;
  logic w_ok;

  assign timeout_hit = (cnt_q == CNT_LAST);
  // A write channel counts as done once its valid has dropped or is handshaking now.
  assign aw_ok = ~awvalid_q | m.m_awready_i;
  assign w_ok  = ~wvalid_q  | m.m_wready_i;

  assign req_ready_o = (state_q == IDLE) & ~resp_valid_q;
  assign stall_o     = (state_q != IDLE) | (req_valid_i & ~req_ready_o);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wmask_d      = wmask_q;
    arvalid_d    = arvalid_q;
    rready_d     = rready_q;
    awvalid_d    = awvalid_q;
    wvalid_d     = wvalid_q;
    bready_d     = bready_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    rdata_d      = rdata_q;

    if (state_q != IDLE) begin
      cnt_d = cnt_q + 8'd1;
    end

    case (state_q)
      IDLE: begin
        if (req_valid_i && req_ready_o) begin
          addr_d  = req_addr_i;
          wdata_d = req_wdata_i;
          wmask_d = req_wmask_i;
          cnt_d   = 8'd0;
          if (req_wen_i) begin
            state_d   = WREQ;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = RADDR;
            arvalid_d = 1'b1;
          end
        end
      end

      RADDR: begin
        if (m.m_arready_i) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RDATA;
          cnt_d     = 8'd0;
        end else if (timeout_hit) begin
          arvalid_d    = 1'b0;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
          rdata_d      = 64'd0;
          state_d      = IDLE;
          cnt_d        = 8'd0;
        end
      end

      RDATA: begin
        rdata_d = rdata_q;
        if (m.m_rvalid_i) begin
          rready_d     = 1'b0;
          rdata_d      = m.m_rdata_i;
          resp_valid_d = 1'b1;
          state_d      = IDLE;
          cnt_d        = 8'd0;
        end else if (timeout_hit) begin
          rready_d     = 1'b0;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
          rdata_d      = 64'd0;
          state_d      = IDLE;
          cnt_d        = 8'd0;
        end
      end

      WREQ: begin
        // Address and data channels complete independently, in either order.
        if (awvalid_q && m.m_awready_i) awvalid_d = 1'b0;
        if (wvalid_q && m.m_wready_i)   wvalid_d  = 1'b0;
        if (aw_ok && w_ok) begin
          awvalid_d = 1'b0;
          wvalid_d  = 1'b0;
          bready_d  = 1'b1;
          state_d   = WRESP;
          cnt_d     = 8'd0;
        end else if (timeout_hit) begin
          awvalid_d    = 1'b0;
          wvalid_d     = 1'b0;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
          state_d      = IDLE;
          cnt_d        = 8'd0;
        end
      end

      WRESP: begin
        if (m.m_bvalid_i) begin
          bready_d     = 1'b0;
          resp_valid_d = 1'b1;
          state_d      = IDLE;
          cnt_d        = 8'd0;
        end else if (timeout_hit) begin
          bready_d     = 1'b0;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
          state_d      = IDLE;
          cnt_d        = 8'd0;
        end
      end

      default: begin
        state_d   = IDLE;
        cnt_d     = 8'd0;
        arvalid_d = 1'b0;
        rready_d  = 1'b0;
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
        bready_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= 8'd0;
      addr_q       <= 32'd0;
      wdata_q      <= 64'd0;
      wmask_q      <= 64'd0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      rdata_q      <= 64'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wmask_q      <= wmask_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      bready_q     <= bready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      rdata_q      <= rdata_d;
    end
  end

  assign resp_valid_o  = resp_valid_q;
  assign resp_err_o    = resp_err_q;
  assign resp_rdata_o  = rdata_q;

  assign m.m_araddr_o  = addr_q;
  assign m.m_arvalid_o = arvalid_q;
  assign m.m_rready_o  = rready_q;
  assign m.m_awaddr_o  = addr_q;
  assign m.m_awvalid_o = awvalid_q;
  assign m.m_wdata_o   = wdata_q;
  assign m.m_wmask_o   = wmask_q;
  assign m.m_wvalid_o  = wvalid_q;
  assign m.m_bready_o  = bready_q;

endmodule
